la_out_bank: RTL

LA_OUT_BANK -- requirements
Module: la_out_bank

---
 rtl/la_out_bank.sv | 118 +++++++++++
 1 files changed

// File: rtl/la_out_bank.sv
// Logic-analyzer output bank: shadowed output words with atomic commit,
// optional auto-commit, and timed pulse overlay on the output bus.
module la_out_bank #(
    parameter int unsigned LA_WIDTH  = 128,
    parameter int unsigned PULSE_LEN = 4,
    localparam int unsigned N        = LA_WIDTH / 32,
    localparam int unsigned AW       = $clog2(2 * N + 1)
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [AW-1:0]       wr_addr,
    input  logic [31:0]         wr_data,
    input  logic [3:0]          wr_strb,
    input  logic                rd_valid,
    input  logic [AW-1:0]       rd_addr,
    output logic [31:0]         rd_data,
    output logic                rd_ack,
    output logic [LA_WIDTH-1:0] la_output,
    output logic                busy
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0][31:0] storage_q;
    logic [N-1:0][31:0] shadow_q;
    logic [N-1:0][31:0] mask_q;
    logic [7:0]         count_q;
    logic               auto_q;

    logic               wr_fire;
    logic               wr_is_sh;
    logic               wr_is_pl;
    logic               wr_is_ctrl;
    logic [IW-1:0]      wr_sh_idx;
    logic [IW-1:0]      wr_pl_idx;
    logic [IW-1:0]      rd_sh_idx;
    logic [IW-1:0]      rd_pl_idx;
    logic [31:0]        sh_merged;
    logic [31:0]        pl_merged;
    logic [31:0]        rd_word;

    // Byte-lane merge of new data over an existing word.
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] data,
                                          input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) r[8*k +: 8] = data[8*k +: 8];
        end
        return r;
    endfunction

    assign busy      = (count_q != 8'd0);
    assign wr_ready  = !busy && !sys_rst;
    assign la_output = storage_q | (busy ? mask_q : '0);

    always_comb begin
        wr_fire    = wr_valid && wr_ready;
        wr_is_sh   = (wr_addr < AW'(N));
        wr_is_pl   = !wr_is_sh && (wr_addr < AW'(2 * N));
        wr_is_ctrl = (wr_addr == AW'(2 * N));
        wr_sh_idx  = IW'(wr_addr);
        wr_pl_idx  = IW'(wr_addr - AW'(N));
        rd_sh_idx  = IW'(rd_addr);
        rd_pl_idx  = IW'(rd_addr - AW'(N));
        sh_merged  = merge(shadow_q[wr_sh_idx], wr_data, wr_strb);
        pl_merged  = merge(mask_q[wr_pl_idx], wr_data, wr_strb);

        // Reads see register state before any same-cycle write.
        rd_word = 32'd0;
        if (rd_addr < AW'(N)) begin
            rd_word = shadow_q[rd_sh_idx];
        end else if (rd_addr < AW'(2 * N)) begin
            rd_word = busy ? mask_q[rd_pl_idx] : 32'd0;
        end else if (rd_addr == AW'(2 * N)) begin
            rd_word = {30'd0, auto_q, 1'b0};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            storage_q <= '0;
            shadow_q  <= '0;
            mask_q    <= '0;
            count_q   <= 8'd0;
            auto_q    <= 1'b0;
            rd_data   <= 32'd0;
            rd_ack    <= 1'b0;
        end else begin
            rd_ack <= rd_valid;
            if (rd_valid) rd_data <= rd_word;

            // Pulse countdown; mask is dropped on the final active cycle.
            if (count_q != 8'd0) begin
                count_q <= count_q - 8'd1;
                if (count_q == 8'd1) mask_q <= '0;
            end

            if (wr_fire) begin
                if (wr_is_sh) begin
                    shadow_q[wr_sh_idx] <= sh_merged;
                    if (auto_q) storage_q[wr_sh_idx] <= sh_merged;
                end else if (wr_is_pl) begin
                    mask_q            <= '0;
                    mask_q[wr_pl_idx] <= pl_merged;
                    if (pl_merged != 32'd0) count_q <= 8'(PULSE_LEN);
                end else if (wr_is_ctrl && wr_strb[0]) begin
                    auto_q <= wr_data[1];
                    if (wr_data[0]) storage_q <= shadow_q;
                end
            end
        end
    end

endmodule
